// File: rtl/aemb2_dwb_sram_rsp.sv
// Wishbone data-bus responder for the AEMB2 dwb port backed by a single-port word SRAM.
// Decodes a base window, inserts WAIT wait states, and returns a one-cycle registered ack.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transfer; a decoded hit captures the request operands
// ST_WAIT | counting wait states; cyc/stb low aborts the transfer
// ST_XFER | exit edge performs the SRAM access and raises ack
// ST_ACK  | ack high for this cycle only; stb is not sampled here
module aemb2_dwb_sram_rsp #(
    parameter int AEMB_DWB = 32,
    parameter int MEM_AW   = 10,
    parameter logic [AEMB_DWB-MEM_AW-3:0] BASE = '0,
    parameter int WAIT     = 0
) (
    input  logic                  gclk,
    input  logic                  grst,
    input  logic [AEMB_DWB-1:2]   dwb_adr_i,
    input  logic [31:0]           dwb_dat_i,
    input  logic [3:0]            dwb_sel_i,
    input  logic                  dwb_stb_i,
    input  logic                  dwb_cyc_i,
    input  logic                  dwb_wre_i,
    input  logic                  dwb_tag_i,
    output logic [31:0]           dwb_dat_o,
    output logic                  dwb_ack_o,
    output logic                  hit_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_ACK} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [MEM_AW-1:0]   r_adr;
    logic [31:0]         r_dat;
    logic [3:0]          r_sel;
    logic                r_wre;
    logic                r_ack;
    logic [31:0]         r_dat_o;
    logic [31:0]         r_mem [2**MEM_AW];

    logic                w_hit;
    logic                w_live;
    logic                w_capture;
    logic                w_access;
    logic                w_ack_nxt;
    logic                w_unused_tag;

    assign w_unused_tag = dwb_tag_i;
    assign w_live       = dwb_cyc_i & dwb_stb_i;
    assign w_hit        = w_live & (dwb_adr_i[AEMB_DWB-1:MEM_AW+2] == BASE);
    assign hit_o        = w_hit;
    assign dwb_ack_o    = r_ack;
    assign dwb_dat_o    = r_dat_o;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_capture = 1'b1;
                    if (WAIT == 0) begin
                        w_state_nxt = ST_XFER;
                    end else begin
                        w_cnt_nxt   = WAIT_LD;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_live) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_XFER;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_XFER: begin
                if (!w_live) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_access    = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_dat_o <= 32'h0;
            r_adr   <= '0;
            r_dat   <= 32'h0;
            r_sel   <= 4'h0;
            r_wre   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            if (w_capture) begin
                r_adr <= dwb_adr_i[MEM_AW+1:2];
                r_dat <= dwb_dat_i;
                r_sel <= dwb_sel_i;
                r_wre <= dwb_wre_i;
            end
            if (w_access && !r_wre) begin
                r_dat_o <= r_mem[r_adr];
            end
        end
    end

    // SRAM array is intentionally not reset; reset still blocks writes via r_state.
    always_ff @(posedge gclk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_access && r_wre && r_sel[i]) begin
                r_mem[r_adr][8*i +: 8] <= r_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_aemb2_dwb_sram_rsp.sv
// Bench for aemb2_dwb_sram_rsp: two instances (WAIT=0/BASE=0 and WAIT=3/BASE=1)
// driven by directed and random transfers against a word/byte-mask memory model.
module tb_aemb2_dwb_sram_rsp;

    logic             gclk = 1'b0;
    logic             grst;
    logic [1:0][29:0] adr;
    logic [1:0][31:0] dat_i;
    logic [1:0][3:0]  sel;
    logic [1:0]       stb, cyc, wre, tg;
    logic [1:0][31:0] dat_o;
    logic [1:0]       ack, hit;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [2][16];
    bit          m_vld [2][16];
    logic [31:0] m_dat [2];
    int          wait_of [2] = '{0, 3};

    always #5 gclk = ~gclk;

    aemb2_dwb_sram_rsp #(.WAIT(0)) u_a (
        .gclk(gclk), .grst(grst),
        .dwb_adr_i(adr[0]), .dwb_dat_i(dat_i[0]), .dwb_sel_i(sel[0]),
        .dwb_stb_i(stb[0]), .dwb_cyc_i(cyc[0]), .dwb_wre_i(wre[0]), .dwb_tag_i(tg[0]),
        .dwb_dat_o(dat_o[0]), .dwb_ack_o(ack[0]), .hit_o(hit[0])
    );

    aemb2_dwb_sram_rsp #(.WAIT(3), .BASE(20'd1)) u_b (
        .gclk(gclk), .grst(grst),
        .dwb_adr_i(adr[1]), .dwb_dat_i(dat_i[1]), .dwb_sel_i(sel[1]),
        .dwb_stb_i(stb[1]), .dwb_cyc_i(cyc[1]), .dwb_wre_i(wre[1]), .dwb_tag_i(tg[1]),
        .dwb_dat_o(dat_o[1]), .dwb_ack_o(ack[1]), .hit_o(hit[1])
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [29:0] waddr(input int u, input int idx);
        return ((u == 1) ? 30'h400 : 30'h0) + 30'(idx);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // Full transfer held until ack; checks decode, latency, data and ack width.
    task automatic xfer(input int u, input bit w, input int idx, input logic [31:0] d,
                        input logic [3:0] s, input string name);
        int n;
        @(negedge gclk);
        adr[u] = waddr(u, idx); dat_i[u] = d; sel[u] = s; wre[u] = w;
        tg[u] = 1'($urandom); cyc[u] = 1'b1; stb[u] = 1'b1;
        #1 check({name, "_hit"}, 32'(hit[u]), 32'd1);
        n = 0;
        do begin
            @(posedge gclk); @(negedge gclk); n++;
        end while (!ack[u] && n < 40);
        check({name, "_latency"}, 32'(n), 32'(wait_of[u] + 2));
        if (w) begin
            m_mem[u][idx] = (m_mem[u][idx] & ~lane_mask(s)) | (d & lane_mask(s));
            m_vld[u][idx] = 1'b1;
        end else begin
            m_dat[u] = m_mem[u][idx];
        end
        check({name, "_dat"}, dat_o[u], m_dat[u]);
        stb[u] = 1'b0; cyc[u] = 1'b0;
        @(negedge gclk);
        check({name, "_ackw"}, 32'(ack[u]), 32'd0);
    endtask

    initial begin
        int n, acks, first, last, dbl;
        logic [31:0] keep;
        grst = 1'b0;
        adr = '0; dat_i = '0; sel = '0; stb = '0; cyc = '0; wre = '0; tg = '0;
        m_dat[0] = 32'h0; m_dat[1] = 32'h0;
        foreach (m_vld[u, i]) m_vld[u][i] = 1'b0;
        repeat (3) @(negedge gclk);
        check("rst_ack_a", 32'(ack[0]), 32'd0);
        check("rst_dat_a", dat_o[0], 32'h0);
        check("rst_ack_b", 32'(ack[1]), 32'd0);
        check("rst_dat_b", dat_o[1], 32'h0);
        grst = 1'b1;

        xfer(0, 1, 5, 32'hDEADBEEF, 4'hF, "wr5");
        xfer(0, 0, 5, 32'h0, 4'h0, "rd5");
        check("rd5_const", dat_o[0], 32'hDEADBEEF);

        xfer(0, 1, 7, 32'h11223344, 4'hF, "wr7");
        xfer(0, 1, 7, 32'hAABBCCDD, 4'b0101, "wr7_lane");
        check("wr7_keep", dat_o[0], 32'hDEADBEEF);
        xfer(0, 0, 7, 32'h0, 4'hF, "rd7");
        check("rd7_const", dat_o[0], 32'h11BB33DD);

        // Decode miss on the BASE=1 instance, then a hit inside its window.
        @(negedge gclk);
        adr[1] = 30'h0; wre[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        #1 check("miss_hit", 32'(hit[1]), 32'd0);
        acks = 0;
        repeat (20) begin
            @(negedge gclk);
            if (ack[1]) acks++;
        end
        check("miss_noack", 32'(acks), 32'd0);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        xfer(1, 1, 0, 32'hCAFEF00D, 4'hF, "b_wr0");
        xfer(1, 0, 0, 32'h0, 4'hF, "b_rd0");

        // Continuous strobe: ack every WAIT+3 cycles, each one cycle wide.
        xfer(1, 1, 9, 32'h5A5A1234, 4'hF, "b_wr9");
        @(negedge gclk);
        adr[1] = waddr(1, 9); wre[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        acks = 0; first = 0; last = 0; dbl = 0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge gclk); @(negedge gclk);
            if (ack[1]) begin
                if (acks == 0) first = c;
                else check("thru_gap", 32'(c - last), 32'd6);
                if (last == c - 1 && acks != 0) dbl++;
                acks++; last = c;
            end
        end
        stb[1] = 1'b0; cyc[1] = 1'b0;
        check("thru_first", 32'(first), 32'd5);
        check("thru_count", 32'(acks), 32'd3);
        check("thru_width", 32'(dbl), 32'd0);
        m_dat[1] = m_mem[1][9];
        check("thru_dat", dat_o[1], 32'h5A5A1234);

        // Abort during wait states.
        xfer(1, 1, 3, 32'h0BADC0DE, 4'hF, "b_wr3");
        keep = dat_o[1];
        @(negedge gclk);
        adr[1] = waddr(1, 3); dat_i[1] = 32'hFFFFFFFF; sel[1] = 4'hF; wre[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge gclk);
            if (ack[1]) acks++;
        end
        check("abort_noack", 32'(acks), 32'd0);
        check("abort_dat", dat_o[1], keep);
        xfer(1, 0, 3, 32'h0, 4'hF, "abort_rd3");
        check("abort_old", dat_o[1], 32'h0BADC0DE);

        // Reset while the write is in its wait states.
        @(negedge gclk);
        adr[1] = waddr(1, 3); dat_i[1] = 32'h12345678; sel[1] = 4'hF; wre[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        grst = 1'b0;
        #1 check("rstmid_ack", 32'(ack[1]), 32'd0);
        check("rstmid_dat", dat_o[1], 32'h0);
        check("rstmid_dat_a", dat_o[0], 32'h0);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge gclk);
            if (ack[1]) acks++;
        end
        grst = 1'b1;
        m_dat[0] = 32'h0; m_dat[1] = 32'h0;
        repeat (4) begin
            @(negedge gclk);
            if (ack[1]) acks++;
        end
        check("rstmid_noack", 32'(acks), 32'd0);
        xfer(1, 0, 3, 32'h0, 4'hF, "rstmid_rd3");
        check("rstmid_old", dat_o[1], 32'h0BADC0DE);

        // Random mix on both instances against the model.
        for (int k = 0; k < 40; k++) begin
            int u, idx;
            bit w;
            logic [3:0] s;
            u = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            w = 1'($urandom);
            s = 4'($urandom);
            if (!m_vld[u][idx]) begin
                w = 1'b1; s = 4'hF;
            end
            xfer(u, w, idx, $urandom, s, w ? "rnd_wr" : "rnd_rd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
